// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : regfile_scoreboard
// Description : Two-read/one-write register file with a per-register
//               outstanding-writer counter. ID allocates destinations, WB
//               writes results and releases counts, flush clears all counts.
//               Optional write-through forwarding: define REGFILE_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_scoreboard #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int CNT_WIDTH  = 2
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [ADDR_WIDTH-1:0] raddr1,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic                  rdata1_valid,
    input  logic [ADDR_WIDTH-1:0] raddr2,
    output logic [DATA_WIDTH-1:0] rdata2,
    output logic                  rdata2_valid,
    input  logic                  alloc_valid,
    input  logic [ADDR_WIDTH-1:0] alloc_addr,
    output logic                  alloc_ready,
    input  logic                  wb_valid,
    input  logic [ADDR_WIDTH-1:0] wb_addr,
    input  logic [DATA_WIDTH-1:0] wb_data,
    input  logic                  flush,
    output logic                  wb_err
);

    localparam int                   C_NUM_REGS = 2**ADDR_WIDTH;
    localparam logic [CNT_WIDTH-1:0] C_CNT_MAX  = '1;
    localparam logic [CNT_WIDTH-1:0] C_CNT_ONE  = CNT_WIDTH'(1);

    logic [DATA_WIDTH-1:0] r_data [C_NUM_REGS];
    logic [CNT_WIDTH-1:0]  r_cnt  [C_NUM_REGS];
    logic                  r_wb_err;

    logic                  w_wb_live;
    logic                  w_alloc_ready;
    logic                  w_alloc_fire;
    logic [DATA_WIDTH-1:0] w_rdata1;
    logic [DATA_WIDTH-1:0] w_rdata2;
    logic                  w_valid1;
    logic                  w_valid2;

    // Register 0 is hardwired, so writebacks to it are not "live".
    assign w_wb_live = wb_valid && (wb_addr != '0);

    // A same-cycle release to the destination frees a slot in a full counter.
    assign w_alloc_ready = (alloc_addr == '0) ||
                           (r_cnt[alloc_addr] != C_CNT_MAX) ||
                           (wb_valid && (wb_addr == alloc_addr));
    assign w_alloc_fire  = alloc_valid && w_alloc_ready && (alloc_addr != '0);

    // Read ports: registered state, optionally overridden by the live writeback.
    always_comb begin
        w_rdata1 = r_data[raddr1];
        w_valid1 = (r_cnt[raddr1] == '0);
        w_rdata2 = r_data[raddr2];
        w_valid2 = (r_cnt[raddr2] == '0);
`ifdef REGFILE_BYPASS_EN
        // The writer being retired this cycle is the last one if cnt <= 1.
        if (w_wb_live && (wb_addr == raddr1)) begin
            w_rdata1 = wb_data;
            w_valid1 = (r_cnt[raddr1] <= C_CNT_ONE);
        end
        if (w_wb_live && (wb_addr == raddr2)) begin
            w_rdata2 = wb_data;
            w_valid2 = (r_cnt[raddr2] <= C_CNT_ONE);
        end
`endif
    end

    // Data, pending counters and sticky underflow flag.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < C_NUM_REGS; i++) begin
                r_data[i] <= '0;
                r_cnt[i]  <= '0;
            end
            r_wb_err <= 1'b0;
        end else begin
            // Data is written regardless of flush.
            if (w_wb_live) begin
                r_data[wb_addr] <= wb_data;
            end
            if (flush) begin
                for (int i = 0; i < C_NUM_REGS; i++) begin
                    r_cnt[i] <= '0;
                end
            end else begin
                for (int i = 1; i < C_NUM_REGS; i++) begin
                    logic v_inc;
                    logic v_dec;
                    v_inc = w_alloc_fire && (alloc_addr == ADDR_WIDTH'(i));
                    v_dec = w_wb_live && (wb_addr == ADDR_WIDTH'(i)) && (r_cnt[i] != '0);
                    if (v_inc && !v_dec) begin
                        r_cnt[i] <= r_cnt[i] + C_CNT_ONE;
                    end else if (v_dec && !v_inc) begin
                        r_cnt[i] <= r_cnt[i] - C_CNT_ONE;
                    end
                end
                // Release of a register with no pending writer is an error.
                if (w_wb_live && (r_cnt[wb_addr] == '0)) begin
                    r_wb_err <= 1'b1;
                end
            end
        end
    end

    assign rdata1       = w_rdata1;
    assign rdata1_valid = w_valid1;
    assign rdata2       = w_rdata2;
    assign rdata2_valid = w_valid2;
    assign alloc_ready  = w_alloc_ready;
    assign wb_err       = r_wb_err;

endmodule
`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_scoreboard
// Description : Scoreboard bench for regfile_scoreboard. A driver issues one
//               operation per cycle, predicts the combinational outputs from a
//               behavioural model and queues them; a monitor compares them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_scoreboard;

    localparam int C_DW   = 32;
    localparam int C_AW   = 5;
    localparam int C_CW   = 2;
    localparam int C_NREG = 2**C_AW;
    localparam int C_CMAX = 2**C_CW - 1;

    logic            clk = 1'b0;
    logic            resetn;
    logic [C_AW-1:0] raddr1, raddr2, alloc_addr, wb_addr;
    logic [C_DW-1:0] rdata1, rdata2, wb_data;
    logic            rdata1_valid, rdata2_valid;
    logic            alloc_valid, alloc_ready, wb_valid, flush, wb_err;

    regfile_scoreboard #(.DATA_WIDTH(C_DW), .ADDR_WIDTH(C_AW), .CNT_WIDTH(C_CW)) u_dut (
        .clk          (clk),
        .resetn       (resetn),
        .raddr1       (raddr1),
        .rdata1       (rdata1),
        .rdata1_valid (rdata1_valid),
        .raddr2       (raddr2),
        .rdata2       (rdata2),
        .rdata2_valid (rdata2_valid),
        .alloc_valid  (alloc_valid),
        .alloc_addr   (alloc_addr),
        .alloc_ready  (alloc_ready),
        .wb_valid     (wb_valid),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .flush        (flush),
        .wb_err       (wb_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [C_DW-1:0] d1;
        logic            v1;
        logic [C_DW-1:0] d2;
        logic            v2;
        logic            ardy;
        logic            err;
    } exp_t;

    exp_t q_exp[$];

    // Behavioural reference: plain arrays of values and outstanding counts.
    int unsigned m_data [C_NREG];
    int          m_cnt  [C_NREG];
    bit          m_err;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [C_DW-1:0] act, input logic [C_DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [C_DW-1:0] pred_data(input int ra, input bit wv, input int wa, input logic [C_DW-1:0] wd);
`ifdef REGFILE_BYPASS_EN
        if (wv && wa != 0 && wa == ra) return wd;
`endif
        return (ra == 0) ? '0 : C_DW'(m_data[ra]);
    endfunction

    function automatic logic pred_valid(input int ra, input bit wv, input int wa);
`ifdef REGFILE_BYPASS_EN
        if (wv && wa != 0 && wa == ra) return (m_cnt[ra] <= 1);
`endif
        return (m_cnt[ra] == 0);
    endfunction

    // Drive one cycle, queue the predicted outputs, advance the model.
    task automatic step(input bit rn, input bit av, input int aa, input bit wv, input int wa,
                        input logic [C_DW-1:0] wd, input bit fl, input int r1, input int r2,
                        input bit do_chk);
        exp_t e;
        bit   rdy;
        @(posedge clk);
        #1;
        resetn      = rn;
        alloc_valid = av;
        alloc_addr  = C_AW'(aa);
        wb_valid    = wv;
        wb_addr     = C_AW'(wa);
        wb_data     = wd;
        flush       = fl;
        raddr1      = C_AW'(r1);
        raddr2      = C_AW'(r2);
        rdy = (aa == 0) || (m_cnt[aa] < C_CMAX) || (wv && wa == aa);
        if (do_chk) begin
            e.d1   = pred_data(r1, wv, wa, wd);
            e.v1   = pred_valid(r1, wv, wa);
            e.d2   = pred_data(r2, wv, wa, wd);
            e.v2   = pred_valid(r2, wv, wa);
            e.ardy = rdy;
            e.err  = m_err;
            q_exp.push_back(e);
        end
        if (!rn) begin
            for (int i = 0; i < C_NREG; i++) begin
                m_data[i] = 0;
                m_cnt[i]  = 0;
            end
            m_err = 0;
        end else begin
            if (wv && wa != 0) m_data[wa] = wd;
            if (fl) begin
                for (int i = 0; i < C_NREG; i++) m_cnt[i] = 0;
            end else begin
                if (wv && wa != 0) begin
                    if (m_cnt[wa] == 0) m_err = 1;
                    else                m_cnt[wa] = m_cnt[wa] - 1;
                end
                if (av && rdy && aa != 0) m_cnt[aa] = m_cnt[aa] + 1;
            end
        end
    endtask

    // Monitor: outputs are combinational, compare mid-cycle when one is queued.
    always @(negedge clk) begin
        if (q_exp.size() > 0) begin
            exp_t e;
            e = q_exp.pop_front();
            chk("rdata1",       rdata1,             e.d1);
            chk("rdata1_valid", C_DW'(rdata1_valid), C_DW'(e.v1));
            chk("rdata2",       rdata2,             e.d2);
            chk("rdata2_valid", C_DW'(rdata2_valid), C_DW'(e.v2));
            chk("alloc_ready",  C_DW'(alloc_ready),  C_DW'(e.ardy));
            chk("wb_err",       C_DW'(wb_err),       C_DW'(e.err));
        end
    end

    initial begin
        resetn = 1'b0; alloc_valid = 1'b0; alloc_addr = '0; wb_valid = 1'b0;
        wb_addr = '0; wb_data = '0; flush = 1'b0; raddr1 = '0; raddr2 = '0;
        for (int i = 0; i < C_NREG; i++) begin m_data[i] = 0; m_cnt[i] = 0; end
        m_err = 0;

        // Reset held two cycles with alloc and wb driven.
        step(0, 1, 5, 1, 5, 32'h55, 0, 5, 6, 0);
        step(0, 1, 7, 1, 7, 32'h77, 1, 7, 5, 1);
        step(1, 0, 0, 0, 0, 0, 0, 5, 7, 1);

        // Single hazard on r5.
        step(1, 1, 5, 0, 0, 0, 0, 5, 0, 1);
        step(1, 0, 0, 0, 0, 0, 0, 5, 5, 1);
        step(1, 0, 0, 1, 5, 32'hDEADBEEF, 0, 5, 1, 1);
        step(1, 0, 0, 0, 0, 0, 0, 5, 5, 1);

        // Multi-writer and saturation on r7.
        step(1, 1, 7, 0, 0, 0, 0, 7, 5, 1);
        step(1, 1, 7, 0, 0, 0, 0, 7, 5, 1);
        step(1, 1, 7, 0, 0, 0, 0, 7, 5, 1);
        step(1, 1, 7, 0, 0, 0, 0, 7, 5, 1);
        step(1, 1, 7, 1, 7, 32'h701, 0, 7, 5, 1);
        step(1, 0, 0, 1, 7, 32'h702, 0, 7, 5, 1);
        step(1, 0, 0, 1, 7, 32'h703, 0, 7, 5, 1);
        step(1, 0, 0, 1, 7, 32'h704, 0, 7, 5, 1);
        step(1, 0, 0, 0, 0, 0, 0, 7, 7, 1);

        // Flush with a same-cycle writeback and a discarded alloc.
        step(1, 1, 3, 0, 0, 0, 0, 3, 4, 1);
        step(1, 1, 4, 0, 0, 0, 0, 3, 4, 1);
        step(1, 1, 4, 1, 3, 32'h11, 1, 3, 4, 1);
        step(1, 0, 0, 0, 0, 0, 0, 3, 4, 1);

        // Underflow cases.
        step(1, 0, 0, 1, 9, 32'h99, 0, 9, 10, 1);
        step(1, 1, 10, 1, 10, 32'hA0, 0, 9, 10, 1);
        step(1, 0, 0, 0, 0, 0, 0, 9, 10, 1);

        // Register 0.
        step(1, 1, 0, 1, 0, 32'hFFFF, 0, 0, 10, 1);
        step(1, 0, 0, 0, 0, 0, 0, 0, 10, 1);

        // Randomized traffic on a narrow address range to provoke hazards.
        for (int n = 0; n < 600; n++) begin
            bit rn, av, wv, fl;
            int aa, wa;
            rn = ($urandom_range(0, 149) != 0);
            av = ($urandom_range(0, 2) != 0);
            aa = $urandom_range(0, 11);
            wv = ($urandom_range(0, 1) != 0);
            wa = $urandom_range(0, 11);
            if ($urandom_range(0, 3) != 0) begin
                for (int k = 0; k < 12; k++) begin
                    int c;
                    c = $urandom_range(1, 11);
                    if (m_cnt[c] > 0) begin wa = c; break; end
                end
            end
            fl = ($urandom_range(0, 39) == 0);
            step(rn, av, aa, wv, wa, $urandom, fl,
                 ($urandom_range(0, 1) != 0) ? wa : $urandom_range(0, 11),
                 ($urandom_range(0, 1) != 0) ? aa : $urandom_range(0, 11), 1);
        end

        // Final reset clears the sticky error.
        step(1, 0, 0, 1, 12, 32'h12, 0, 12, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 12, 0, 1);
        step(1, 0, 0, 0, 0, 0, 0, 12, 0, 1);

        @(posedge clk);
        @(posedge clk);
        n_checks++;
        if (q_exp.size() != 0) begin
            n_errors++;
            $display("FAIL queue_drain: %0d entries left, expected 0", q_exp.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
Parametrised successor of the core's register file with a built-in scoreboard. Each architectural register has a small outstanding-writer counter instead of a single valid bit, so several in-flight instructions may target the same register. Sits between ID (read and allocate) and WB (write and release). Global flush on exception or branch recovery.

Parameters:
DATA_WIDTH, 32, register data width
ADDR_WIDTH, 5, register index width; NUM_REGS = 2**ADDR_WIDTH
CNT_WIDTH, 2, pending-counter width; max outstanding writes per register CNT_MAX = 2**CNT_WIDTH-1

Ports:
clk  in  1  clock, all state updates on rising edge
resetn  in  1  synchronous active-low reset
raddr1  in  ADDR_WIDTH  read port 1 index
rdata1  out  DATA_WIDTH  read port 1 data (combinational)
rdata1_valid  out  1  read port 1 has no pending writer
raddr2  in  ADDR_WIDTH  read port 2 index
rdata2  out  DATA_WIDTH  read port 2 data (combinational)
rdata2_valid  out  1  read port 2 has no pending writer
alloc_valid  in  1  ID issues an instruction writing alloc_addr
alloc_addr  in  ADDR_WIDTH  destination being allocated
alloc_ready  out  1  allocation accepted this cycle (combinational)
wb_valid  in  1  WB writes a result and releases one pending count
wb_addr  in  ADDR_WIDTH  writeback destination
wb_data  in  DATA_WIDTH  writeback data
flush  in  1  clear all pending counters
wb_err  out  1  sticky: writeback released a register whose counter was 0

Behaviour:
- Reset (resetn=0 at edge): all data regs 0, all counters 0, wb_err 0. Reset overrides flush, alloc and wb.
- Register 0: reads data 0 with valid 1; never written; counter is always 0; alloc to 0 accepted (alloc_ready=1) with no effect; wb to 0 ignored, including the wb_err check.
- Read (combinational): rdataN = reg[raddrN]; rdataN_valid = (cnt[raddrN]==0). Bypass rules are under Optional Feature.
- alloc_ready = (alloc_addr==0) or (cnt[alloc_addr] != CNT_MAX) or (wb_valid and wb_addr==alloc_addr). A release in the same cycle frees a slot.
- An accepted alloc is alloc_valid and alloc_ready together. Allocation with alloc_ready=0 is dropped; ID must stall and hold.
- Writeback, wb_valid and wb_addr!=0: reg[wb_addr] <= wb_data next edge, unconditionally, including during flush.
- Counter update per register r, when no flush:
  - inc = accepted alloc to r; dec = wb to r with cnt[r]!=0.
  - inc only: +1. dec only: -1. Both: unchanged.
  - wb to r with cnt[r]==0 and no same-cycle alloc to r: cnt stays 0 and wb_err <= 1.
  - wb to r with cnt[r]==0 and a same-cycle alloc to r: cnt becomes 1 and wb_err <= 1. The alloc is counted; the release is not.
- Flush: all counters <= 0 next edge. Same-cycle alloc is discarded. Same-cycle wb data is still written. wb_err is not set during flush.
- wb_err clears only on reset.
- Latency: alloc is visible to reads the next cycle. Same-cycle reads see pre-alloc state.

Optional Feature:
Macro REGFILE_BYPASS_EN.
- Defined: write-through forwarding. When wb_valid, wb_addr!=0 and wb_addr==raddrN:
  - rdataN = wb_data.
  - rdataN_valid = 1 if cnt[raddrN]<=1, otherwise 0.
  - A same-cycle alloc to that register is ignored for the read.
- Undefined: reads reflect registered state only; the writeback is visible the next cycle.

Test Plan:
- Reset: hold resetn=0 2 cycles with alloc and wb driven -> all reads 0/valid 1, wb_err 0, no counter change.
- Single hazard: alloc r5; next cycle read r5 -> valid 0. wb r5=0xDEADBEEF; the cycle after -> rdata 0xDEADBEEF, valid 1. With REGFILE_BYPASS_EN, valid 1 and the data appear in the wb cycle.
- Multi-writer and saturation (CNT_WIDTH=2):
  - alloc r7 three times -> alloc_ready 0 on the 4th attempt.
  - 4th alloc with a same-cycle wb r7 -> accepted, cnt stays 3.
  - Three further wbs -> valid 1 only after the last one.
- Flush: alloc r3,r4; flush with wb r3=0x11 in the same cycle -> next cycle both valid 1, r3=0x11, r4 unchanged, wb_err 0.
- Underflow: wb r9 with cnt 0 -> r9 written, cnt 0, wb_err 1 and it stays 1 until reset. Simultaneous alloc+wb r10 with cnt 0 -> cnt 1, wb_err 1.
- r0: alloc r0 and wb r0=0xFFFF -> alloc_ready 1, read r0 gives 0/valid 1, wb_err unchanged.
